// File: rtl/lvds_serializer_tx.sv
// Parallel-to-serial LVDS transmitter: splits each word across LANES serial lanes (MSB first),
// forwards a frame clock and frame marker, and sends training/idle words when there is no data.
module lvds_serializer_tx #(
  parameter int unsigned                    DATA_WIDTH    = 8,
  parameter int unsigned                    LANES         = 2,
  parameter logic [DATA_WIDTH/LANES-1:0]    TRAIN_PATTERN = 4'b1010,
  parameter logic [DATA_WIDTH/LANES-1:0]    IDLE_PATTERN  = '0
) (
  input  logic                  input_clk,
  input  logic                  arst,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic                  train_en,
  output logic [LANES-1:0]      output_data,
  output logic                  data_clk,
  output logic                  frame_start,
  output logic [15:0]           underrun_cnt
);

  localparam int unsigned BPL  = DATA_WIDTH / LANES;
  localparam int unsigned CntW = $clog2(BPL);
  localparam logic [CntW-1:0] CntMax  = CntW'(BPL - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'((BPL + 1) / 2);

  if ((DATA_WIDTH % LANES) != 0 || (DATA_WIDTH / LANES) < 2) begin : gen_cfg_err
    $error("lvds_serializer_tx: DATA_WIDTH/LANES must be an integer >= 2");
  end

  typedef enum logic [1:0] {StIdle, StTrain, StData} state_e;

  state_e                       state_q, state_d;
  logic [CntW-1:0]              bit_cnt_q, bit_cnt_d;
  logic [LANES-1:0][BPL-1:0]    shift_q, shift_d;
  logic [DATA_WIDTH-1:0]        hold_q, hold_d;
  logic                         hold_valid_q, hold_valid_d;
  logic [15:0]                  underrun_q, underrun_d;

  logic boundary, drain, handshake;

  assign boundary  = (bit_cnt_q == CntMax);
  assign drain     = boundary & ~train_en & hold_valid_q;
  assign handshake = input_valid & input_ready;

  always_ff @(posedge input_clk) begin
    if (arst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= CntMax;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      underrun_q   <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      underrun_q   <= underrun_d;
    end
  end

  // Transitions are only evaluated on the last bit of a word.
  always_comb begin
    state_d = state_q;
    if (boundary) begin
      if (train_en) begin
        state_d = StTrain;
      end else if (hold_valid_q) begin
        state_d = StData;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    bit_cnt_d = boundary ? '0 : bit_cnt_q + CntW'(1);

    shift_d = shift_q;
    for (int k = 0; k < LANES; k++) begin
      if (boundary) begin
        unique case (state_d)
          StTrain: shift_d[k] = TRAIN_PATTERN;
          StData:  shift_d[k] = hold_q[k*BPL +: BPL];
          default: shift_d[k] = IDLE_PATTERN;
        endcase
      end else begin
        shift_d[k] = shift_q[k] << 1;
      end
    end

    // A new word accepted on the draining boundary refills the hold register.
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (handshake) begin
      hold_d       = input_data;
      hold_valid_d = 1'b1;
    end else if (drain) begin
      hold_valid_d = 1'b0;
    end

    underrun_d = underrun_q;
    if (boundary && state_q == StData && state_d == StIdle && underrun_q != 16'hFFFF) begin
      underrun_d = underrun_q + 16'd1;
    end

    output_data = '0;
    for (int k = 0; k < LANES; k++) begin
      output_data[k] = ~arst & shift_q[k][BPL-1];
    end
    data_clk     = ~arst & (bit_cnt_q < HalfCnt);
    frame_start  = ~arst & (bit_cnt_q == '0);
    input_ready  = arst | ~hold_valid_q | drain;
    underrun_cnt = underrun_q;
  end

endmodule

// File: tb/tb_lvds_serializer_tx.sv
// Table-driven bench for lvds_serializer_tx: default 8-bit/2-lane instance plus a 12-bit/4-lane
// instance for the odd bits-per-lane frame clock and mid-word reset.
module tb_lvds_serializer_tx;

  logic input_clk = 1'b0;
  always #5 input_clk = ~input_clk;

  logic        arst, input_valid, train_en, input_ready, data_clk, frame_start;
  logic [7:0]  input_data;
  logic [1:0]  output_data;
  logic [15:0] underrun_cnt;

  logic        arst3, valid3, train3, ready3, dclk3, fs3;
  logic [11:0] data3;
  logic [3:0]  out3;
  logic [15:0] ucnt3;

  int checks = 0;
  int errors = 0;
  int row3_no = 0;

  lvds_serializer_tx dut (
    .input_clk    (input_clk),
    .arst         (arst),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .train_en     (train_en),
    .output_data  (output_data),
    .data_clk     (data_clk),
    .frame_start  (frame_start),
    .underrun_cnt (underrun_cnt)
  );

  lvds_serializer_tx #(
    .DATA_WIDTH    (12),
    .LANES         (4),
    .TRAIN_PATTERN (3'b101),
    .IDLE_PATTERN  (3'b011)
  ) dut3 (
    .input_clk    (input_clk),
    .arst         (arst3),
    .input_data   (data3),
    .input_valid  (valid3),
    .input_ready  (ready3),
    .train_en     (train3),
    .output_data  (out3),
    .data_clk     (dclk3),
    .frame_start  (fs3),
    .underrun_cnt (ucnt3)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        train;
    logic [1:0]  out;
    logic        fs;
    logic        dclk;
    logic        rdy;
    logic [15:0] ucnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic valid, input logic [7:0] data,
                              input logic train, input logic [1:0] out, input logic fs,
                              input logic dclk, input logic rdy, input logic [15:0] ucnt);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.train = train;
    v.out = out; v.fs = fs; v.dclk = dclk; v.rdy = rdy; v.ucnt = ucnt;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle on the 4-lane instance: drive, sample mid-cycle, advance past the edge.
  task automatic row3(input logic rst, input logic v, input logic [11:0] d, input logic [3:0] eo,
                      input logic efs, input logic edc, input logic erdy);
    arst3 = rst; valid3 = v; data3 = d;
    #3;
    check($sformatf("cfg3 row%0d out", row3_no), 16'(out3), 16'(eo));
    check($sformatf("cfg3 row%0d frame_start", row3_no), 16'(fs3), 16'(efs));
    check($sformatf("cfg3 row%0d data_clk", row3_no), 16'(dclk3), 16'(edc));
    check($sformatf("cfg3 row%0d ready", row3_no), 16'(ready3), 16'(erdy));
    row3_no++;
    @(posedge input_clk); #1;
  endtask

  initial begin
    arst = 1'b1; input_valid = 1'b0; input_data = '0; train_en = 1'b0;
    arst3 = 1'b1; valid3 = 1'b0; data3 = '0; train3 = 1'b0;

    // Basic transfer of A5, then underrun; idle words afterwards must not count again.
    add(0, 1, 8'hA5, 0, 2'b00, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 2'b00, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 2'b00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 2'b00, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 2'b10, 1, 1, 1, 0);
    add(0, 0, 8'h00, 0, 2'b01, 0, 1, 1, 0);
    add(0, 0, 8'h00, 0, 2'b10, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 2'b01, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 2'b00, 1, 1, 1, 1);
    add(0, 0, 8'h00, 0, 2'b00, 0, 1, 1, 1);
    add(0, 0, 8'h00, 0, 2'b00, 0, 0, 1, 1);
    add(0, 0, 8'h00, 0, 2'b00, 0, 0, 1, 1);
    add(0, 0, 8'h00, 0, 2'b00, 1, 1, 1, 1);
    // Back-to-back 3C, F0; F0 is accepted on the boundary that drains 3C (hold full).
    add(1, 0, 8'h00, 0, 2'b00, 0, 0, 1, 1);
    add(0, 1, 8'h3C, 0, 2'b00, 0, 0, 1, 0);
    add(0, 1, 8'hF0, 0, 2'b00, 1, 1, 0, 0);
    add(0, 1, 8'hF0, 0, 2'b00, 0, 1, 0, 0);
    add(0, 1, 8'hF0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 1, 8'hF0, 0, 2'b00, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 2'b01, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 2'b01, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 2'b10, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 2'b10, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 2'b10, 1, 1, 1, 0);
    add(0, 0, 8'h00, 0, 2'b10, 0, 1, 1, 0);
    add(0, 0, 8'h00, 0, 2'b10, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 2'b10, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 2'b00, 1, 1, 1, 1);
    // Training for three boundaries with 5A held; mid-word train_en toggles are ignored.
    add(1, 0, 8'h00, 0, 2'b00, 0, 0, 1, 1);
    add(0, 1, 8'h5A, 0, 2'b00, 0, 0, 1, 0);
    add(0, 0, 8'h00, 1, 2'b00, 1, 1, 0, 0);
    add(0, 0, 8'h00, 1, 2'b00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 2'b00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 2'b00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 2'b11, 1, 1, 0, 0);
    add(0, 0, 8'h00, 1, 2'b00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 2'b11, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 2'b00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 2'b11, 1, 1, 0, 0);
    add(0, 0, 8'h00, 1, 2'b00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 2'b11, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 2'b00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 2'b11, 1, 1, 0, 0);
    add(0, 0, 8'h00, 1, 2'b00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 2'b11, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 2'b00, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 2'b01, 1, 1, 1, 0);
    add(0, 0, 8'h00, 0, 2'b10, 0, 1, 1, 0);
    add(0, 0, 8'h00, 0, 2'b01, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 2'b10, 0, 0, 1, 0);

    repeat (2) @(posedge input_clk);
    #1;
    check("reset out", 16'(output_data), 16'h0);
    check("reset frame_start", 16'(frame_start), 16'h0);
    check("reset data_clk", 16'(data_clk), 16'h0);
    check("reset ready", 16'(input_ready), 16'h1);
    check("reset underrun", underrun_cnt, 16'h0);

    foreach (vecs[i]) begin
      arst = vecs[i].rst; input_valid = vecs[i].valid;
      input_data = vecs[i].data; train_en = vecs[i].train;
      #3;
      check($sformatf("row%0d out", i), 16'(output_data), 16'(vecs[i].out));
      check($sformatf("row%0d frame_start", i), 16'(frame_start), 16'(vecs[i].fs));
      check($sformatf("row%0d data_clk", i), 16'(data_clk), 16'(vecs[i].dclk));
      check($sformatf("row%0d ready", i), 16'(input_ready), 16'(vecs[i].rdy));
      check($sformatf("row%0d underrun", i), underrun_cnt, vecs[i].ucnt);
      @(posedge input_clk); #1;
    end
    arst = 1'b0; input_valid = 1'b0; train_en = 1'b0;

    // Lanes of B11 are 001,010,100,101; FFF is held and then dropped by the mid-word reset.
    row3(0, 1, 12'hB11, 4'b0000, 0, 0, 1);
    row3(0, 0, 12'h000, 4'b0000, 1, 1, 0);
    row3(0, 0, 12'h000, 4'b1111, 0, 1, 0);
    row3(0, 0, 12'h000, 4'b1111, 0, 0, 1);
    row3(0, 1, 12'hFFF, 4'b1100, 1, 1, 1);
    row3(0, 0, 12'h000, 4'b0010, 0, 1, 0);
    row3(1, 0, 12'h000, 4'b0000, 0, 0, 1);
    row3(0, 0, 12'h000, 4'b0000, 0, 0, 1);
    row3(0, 0, 12'h000, 4'b0000, 1, 1, 1);
    row3(0, 0, 12'h000, 4'b1111, 0, 1, 1);
    row3(0, 0, 12'h000, 4'b1111, 0, 0, 1);
    row3(0, 0, 12'h000, 4'b0000, 1, 1, 1);
    check("cfg3 underrun", ucnt3, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
